mux_rr_arbiter_16bit: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit 4:1 datapath multiplexer among four requesters and forwards the selected word through a single registered output stage with valid/ready flow control. It drives the mux select lines A1:A0 from its grant state, acknowledges each accepted word to its requester, and caps how many consecutive words one requester may move while others wait. It sits between four 16-bit word sources and one downstream consumer.

---
 rtl/mux_arb_pkg.sv | 23 ++
 rtl/mux_rr_arbiter_16bit_if.sv | 27 ++
 rtl/mux_4x1_16bit.sv | 23 ++
 rtl/mux_rr_arbiter_16bit.sv | 115 +++++++++++
 tb/tb_mux_rr_arbiter_16bit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin 4:1 word arbiter.
// The grant search helper is used by the arbiter's next-state logic.
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MAX_BURST_DEFAULT = 4;
  localparam int NUM_REQ           = 4;

  // First set bit of req, searching ptr, ptr+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_16bit_if.sv
// Bus between four word sources, the arbiter and one downstream consumer.
// Handshakes: req[i] is held with stable I<i> until ack[i] is seen at a rising edge;
// a word moves downstream on every rising edge where out_valid && out_ready.
interface mux_rr_arbiter_16bit_if;
  logic [3:0]  req;
  logic [15:0] I0;
  logic [15:0] I1;
  logic [15:0] I2;
  logic [15:0] I3;
  logic        A0;
  logic        A1;
  logic [3:0]  ack;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  modport master (
    input  req, I0, I1, I2, I3, out_ready,
    output A0, A1, ack, out_data, out_src, out_valid
  );

  modport slave (
    output req, I0, I1, I2, I3, out_ready,
    input  A0, A1, ack, out_data, out_src, out_valid
  );
endinterface

// File: rtl/mux_4x1_16bit.sv
// Plain combinational 16-bit 4:1 multiplexer, select {A1,A0}.
module mux_4x1_16bit (
  input  logic [15:0] I0,
  input  logic [15:0] I1,
  input  logic [15:0] I2,
  input  logic [15:0] I3,
  input  logic        A0,
  input  logic        A1,
  output logic [15:0] Q
);

  always_comb begin
    Q = I0;
    case ({A1, A0})
      2'b00: Q = I0;
      2'b01: Q = I1;
      2'b10: Q = I2;
      2'b11: Q = I3;
      default: Q = I0;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter_16bit.sv
// Round-robin arbiter sharing one 4:1 word mux among four requesters, with a
// registered valid/ready output stage and a per-grant burst cap.
module mux_rr_arbiter_16bit
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mux_rr_arbiter_16bit_if.master      bus,
  output state_t                      dbg_state,
  output logic [1:0]                  dbg_ptr
);

  state_t      state, state_nxt;
  logic [1:0]  sel, sel_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [3:0]  burst_cnt, burst_nxt;
  logic [15:0] mux_q;
  logic [15:0] out_data_q;
  logic [1:0]  out_src_q;
  logic        out_valid_q;
  logic [3:0]  sel_onehot;
  logic        transfer;
  logic        others_pending;
  logic        burst_hit;

  mux_4x1_16bit u_mux (
    .I0 (bus.I0),
    .I1 (bus.I1),
    .I2 (bus.I2),
    .I3 (bus.I3),
    .A0 (sel[0]),
    .A1 (sel[1]),
    .Q  (mux_q)
  );

  assign sel_onehot     = 4'b0001 << sel;
  assign transfer       = (state == GRANT) && bus.req[sel] && (!out_valid_q || bus.out_ready);
  assign others_pending = |(bus.req & ~sel_onehot);
  assign burst_hit      = (burst_cnt + 4'd1) == 4'(MAX_BURST);

  // Release on a dropped request, or on a capped burst only when someone else waits;
  // a lone requester just restarts its count and keeps streaming.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = GRANT;
          sel_nxt   = rr_pick(bus.req, ptr);
          burst_nxt = '0;
        end
      end
      GRANT: begin
        if (!bus.req[sel]) begin
          state_nxt = IDLE;
          ptr_nxt   = sel + 2'd1;
        end else if (transfer) begin
          if (burst_hit) begin
            burst_nxt = '0;
            if (others_pending) begin
              state_nxt = IDLE;
              ptr_nxt   = sel + 2'd1;
            end
          end else begin
            burst_nxt = burst_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (transfer) begin
      out_data_q  <= mux_q;
      out_src_q   <= sel;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.A0        = sel[0];
  assign bus.A1        = sel[1];
  assign bus.ack       = transfer ? sel_onehot : 4'b0000;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
  assign dbg_state     = state;
  assign dbg_ptr       = ptr;

endmodule

// File: tb/tb_mux_rr_arbiter_16bit.sv
// Directed bench for mux_rr_arbiter_16bit: requester model, output scoreboard,
// arbitration order, backpressure, lone-requester streaming, release and reset.
module tb_mux_rr_arbiter_16bit;
  import mux_arb_pkg::*;

  logic clk;
  logic rst_n;
  state_t     dbg_state;
  logic [1:0] dbg_ptr;

  mux_rr_arbiter_16bit_if bus ();

  mux_rr_arbiter_16bit #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bench state ----------------
  int          checks;
  int          errors;
  int          remaining [4];
  logic [15:0] cur_data  [4];
  logic [17:0] exp_q[$];

  logic [3:0]  s_ack;
  logic [1:0]  s_sel;
  logic        s_valid;
  logic [15:0] s_data;
  logic [1:0]  s_src;
  state_t      s_state;
  logic [1:0]  s_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int ack_idx(input logic [3:0] a);
    case (a)
      4'b0000: return 4;
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 5;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (remaining[i] > 0);
    bus.req = r;
    bus.I0  = cur_data[0];
    bus.I1  = cur_data[1];
    bus.I2  = cur_data[2];
    bus.I3  = cur_data[3];
  endtask

  // One clock: sample at the falling edge, score output, log acks, then after the
  // rising edge advance every acknowledged requester to its next word.
  task automatic cycle();
    logic [17:0] exp_v;
    @(negedge clk);
    s_ack   = bus.ack;
    s_sel   = {bus.A1, bus.A0};
    s_valid = bus.out_valid;
    s_data  = bus.out_data;
    s_src   = bus.out_src;
    s_state = dbg_state;
    s_ptr   = dbg_ptr;
    if (s_valid && bus.out_ready) begin
      if (exp_q.size() > 0) exp_v = exp_q.pop_front();
      else exp_v = 'x;
      check("sb_word", {14'd0, s_src, s_data}, {14'd0, exp_v});
    end
    for (int i = 0; i < 4; i++)
      if (s_ack[i]) exp_q.push_back({2'(i), cur_data[i]});
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (s_ack[i]) begin
        remaining[i]--;
        cur_data[i] = 16'($urandom_range(0, 65535));
      end
    drive();
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      cycle();
      done = (exp_q.size() == 0) && !s_valid &&
             (remaining[0] + remaining[1] + remaining[2] + remaining[3] == 0);
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      remaining[i] = 0;
      cur_data[i]  = 16'($urandom_range(0, 65535));
    end
    drive();
    #1 rst_n = 1'b0;
    #2;
    check("rst_ack",   bus.ack, 4'b0000);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_data",  bus.out_data, 16'h0000);
    check("rst_src",   bus.out_src, 2'd0);
    check("rst_sel",   {bus.A1, bus.A0}, 2'b00);
    check("rst_state", dbg_state, IDLE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester latency
    remaining[0] = 1;
    cur_data[0]  = 16'hA5A5;
    drive();
    cycle();
    check("single_c0_state", s_state, IDLE);
    check("single_c0_ack",   s_ack, 4'b0000);
    cycle();
    check("single_c1_ack",   s_ack, 4'b0001);
    check("single_c1_sel",   s_sel, 2'b00);
    cycle();
    check("single_c2_valid", s_valid, 1'b1);
    check("single_c2_data",  s_data, 16'hA5A5);
    check("single_c2_src",   s_src, 2'd0);
    drain("single_drain");

    // All four requesting: 4-word bursts, one bubble between grants
    do_reset();
    for (int i = 0; i < 4; i++) remaining[i] = 8;
    drive();
    for (int n = 0; n < 41; n++) begin
      int e;
      int m;
      if (n == 0) e = 4;
      else begin
        m = (n - 1) % 5;
        e = (m == 4) ? 4 : ((n - 1) / 5) % 4;
      end
      cycle();
      check("rr_order", ack_idx(s_ack), e);
    end
    drain("rr_drain");

    // Backpressure on requester 1's stream
    remaining[1] = 6;
    drive();
    repeat (3) cycle();
    bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cycle();
      check("stall_ack",   s_ack, 4'b0000);
      check("stall_valid", s_valid, 1'b1);
      check("stall_data",  s_data, (exp_q.size() > 0) ? exp_q[0][15:0] : 16'hxxxx);
    end
    bus.out_ready = 1'b1;
    drain("stall_drain");

    // Lone requester 2 streams past the burst cap without a bubble
    remaining[2] = 10;
    drive();
    cycle();
    for (int n = 0; n < 10; n++) begin
      cycle();
      check("lone_ack", s_ack, 4'b0100);
      check("lone_sel", s_sel, 2'b10);
    end
    cycle();
    check("lone_done_ack", s_ack, 4'b0000);
    drain("lone_drain");

    // Requester 1 drops after 2 words while requester 3 waits
    remaining[1] = 2;
    drive();
    cycle();
    remaining[3] = 3;
    drive();
    cycle();
    check("drop_w1_ack", s_ack, 4'b0010);
    cycle();
    check("drop_w2_ack", s_ack, 4'b0010);
    cycle();
    check("drop_rel_ack",   s_ack, 4'b0000);
    check("drop_rel_state", s_state, GRANT);
    cycle();
    check("drop_idle_state", s_state, IDLE);
    check("drop_idle_ptr",   s_ptr, 2'd2);
    cycle();
    check("drop_next_ack", s_ack, 4'b1000);
    check("drop_next_sel", s_sel, 2'b11);
    drain("drop_drain");

    // Reset in the middle of a burst
    for (int i = 0; i < 4; i++) remaining[i] = 6;
    drive();
    repeat (4) cycle();
    rst_n = 1'b0;
    #2;
    check("midrst_ack",   bus.ack, 4'b0000);
    check("midrst_valid", bus.out_valid, 1'b0);
    check("midrst_data",  bus.out_data, 16'h0000);
    check("midrst_a1",    bus.A1, 1'b0);
    check("midrst_a0",    bus.A0, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    check("postrst_state", s_state, IDLE);
    check("postrst_ack0",  s_ack, 4'b0000);
    cycle();
    check("postrst_grant", s_ack, 4'b0001);
    drain("postrst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
